// File: rtl/config_port_arbiter_if.sv
// Bundle of per-source write ports and the forwarded ConfigFSM-side bus.
// Latency: none (wiring only); the Checksum signal exists only with CONFIG_CHECKSUM_EN.
// Backpressure: none; sources strobe unconditionally and non-granted strobes are dropped.
interface config_port_arbiter_if #(
  parameter int NUM_PORTS = 3,
  parameter int SEL_W     = 2,
  parameter int COUNT_W   = 16
);
  logic [NUM_PORTS*32-1:0] PortWriteData;
  logic [NUM_PORTS-1:0]    PortWriteStrobe;
  logic [NUM_PORTS-1:0]    PortActive;
  logic [31:0]             ConfigWriteData;
  logic                    ConfigWriteStrobe;
  logic                    FSMReset;
  logic [SEL_W-1:0]        ActivePort;
  logic                    Busy;
  logic [COUNT_W-1:0]      WordCount;
  logic                    Collision;
`ifdef CONFIG_CHECKSUM_EN
  logic [31:0]             Checksum;
`endif

  // Arbiter side
  modport slave (
    input  PortWriteData, PortWriteStrobe, PortActive,
    output ConfigWriteData, ConfigWriteStrobe, FSMReset, ActivePort, Busy, WordCount, Collision
`ifdef CONFIG_CHECKSUM_EN
    , output Checksum
`endif
  );

  // Source / observer side
  modport master (
    output PortWriteData, PortWriteStrobe, PortActive,
    input  ConfigWriteData, ConfigWriteStrobe, FSMReset, ActivePort, Busy, WordCount, Collision
`ifdef CONFIG_CHECKSUM_EN
    , input Checksum
`endif
  );
endinterface

// File: rtl/config_port_arbiter.sv
// Non-preemptive N-source arbiter forwarding config words to ConfigFSM; optional CONFIG_CHECKSUM_EN adds a session checksum.
// Latency: forwarded strobe/data appear exactly 1 cycle after the granted source's strobe.
// Backpressure: none; strobes from non-granted sources while busy are dropped and flagged in Collision.
module config_port_arbiter #(
  parameter int NUM_PORTS   = 3,
  parameter int SEL_W       = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int COUNT_W     = 16
) (
  input logic                  CLK,
  input logic                  Resetn,
  config_port_arbiter_if.slave bus
);
  localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic               start;

  logic [SEL_W-1:0]   lowest;
  logic               any_active;
  logic               gnt_active;
  logic               gnt_strobe;
  logic [31:0]        gnt_data;
  logic               other_strobe;
  logic               busy;

  logic [31:0]        cfg_data_q;
  logic               cfg_strobe_q;
  logic               fsm_reset_q;
  logic [COUNT_W-1:0] word_cnt_q;
  logic               collision_q;

  assign busy = (state_q != IDLE);

  // Decode the granted source's signals, the strobes of everyone else, and the lowest-index requester
  always_comb begin
    lowest       = '0;
    any_active   = |bus.PortActive;
    gnt_active   = 1'b0;
    gnt_strobe   = 1'b0;
    gnt_data     = '0;
    other_strobe = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.PortActive[i]) lowest = SEL_W'(i);
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == SEL_W'(i)) begin
        gnt_active = bus.PortActive[i];
        gnt_strobe = bus.PortWriteStrobe[i];
        gnt_data   = bus.PortWriteData[32*i +: 32];
      end else begin
        other_strobe = other_strobe | bus.PortWriteStrobe[i];
      end
    end
  end

  // Session FSM: lock onto a source, ride out short Active gaps in HOLD, then release
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_active) begin
          state_d = GRANT;
          grant_d = lowest;
          start   = 1'b1;
        end
      end
      GRANT: begin
        if (!gnt_active) begin
          if (HOLD_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            hold_d  = HOLD_W'(HOLD_CYCLES);
          end
        end
      end
      HOLD: begin
        hold_d = hold_q - HOLD_W'(1);
        if (gnt_active)                  state_d = GRANT;
        else if (hold_q == HOLD_W'(1))   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, hold counter and granted index
  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      state_q <= IDLE;
      hold_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
    end
  end

  // Registered forwarding, session-start pulse, saturating word count and sticky collision flag
  always_ff @(posedge CLK) begin
    if (!Resetn) begin
      cfg_data_q   <= '0;
      cfg_strobe_q <= 1'b0;
      fsm_reset_q  <= 1'b0;
      word_cnt_q   <= '0;
      collision_q  <= 1'b0;
    end else begin
      fsm_reset_q  <= start;
      collision_q  <= collision_q | (busy & other_strobe);
      cfg_strobe_q <= busy & gnt_strobe;
      if (busy && gnt_strobe)  cfg_data_q <= gnt_data;
      else if (!busy)          cfg_data_q <= '0;
      if (start)                                    word_cnt_q <= '0;
      else if (busy && gnt_strobe && word_cnt_q != '1) word_cnt_q <= word_cnt_q + COUNT_W'(1);
    end
  end

`ifdef CONFIG_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running mod-2^32 sum of words forwarded this session, updated alongside the forwarded strobe
  always_ff @(posedge CLK) begin
    if (!Resetn)                 checksum_q <= '0;
    else if (start)              checksum_q <= '0;
    else if (busy && gnt_strobe) checksum_q <= checksum_q + gnt_data;
  end

  assign bus.Checksum = checksum_q;
`endif

  assign bus.ConfigWriteData   = cfg_data_q;
  assign bus.ConfigWriteStrobe = cfg_strobe_q;
  assign bus.FSMReset          = fsm_reset_q;
  assign bus.ActivePort        = busy ? grant_q : '0;
  assign bus.Busy              = busy;
  assign bus.WordCount         = word_cnt_q;
  assign bus.Collision         = collision_q;
endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed bench for config_port_arbiter: main instance (HOLD 16, COUNT_W 16) and a small one (HOLD 0, COUNT_W 2).
// Inputs are driven 1 time unit after each rising edge; outputs are checked at the same point.
// Expected values are hand-derived from the arbiter behaviour, not read back from the design.
module tb_config_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  config_port_arbiter_if #(.NUM_PORTS(3), .SEL_W(2), .COUNT_W(16)) bus ();
  config_port_arbiter_if #(.NUM_PORTS(3), .SEL_W(2), .COUNT_W(2))  sbus ();

  config_port_arbiter #(.NUM_PORTS(3), .SEL_W(2), .HOLD_CYCLES(16), .COUNT_W(16)) u_dut (
    .CLK(clk), .Resetn(rst_n), .bus(bus)
  );

  config_port_arbiter #(.NUM_PORTS(3), .SEL_W(2), .HOLD_CYCLES(0), .COUNT_W(2)) u_small (
    .CLK(clk), .Resetn(rst_n), .bus(sbus)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.PortWriteData   = '0;
    bus.PortWriteStrobe = '0;
    bus.PortActive      = '0;
    sbus.PortWriteData   = '0;
    sbus.PortWriteStrobe = '0;
    sbus.PortActive      = '0;
    tick(2);

    // Reset state
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_fsmreset", 32'(bus.FSMReset), 0);
    chk("rst_activeport", 32'(bus.ActivePort), 0);
    chk("rst_wordcount", 32'(bus.WordCount), 0);
    chk("rst_collision", 32'(bus.Collision), 0);
    chk("rst_strobe", 32'(bus.ConfigWriteStrobe), 0);
    chk("rst_data", bus.ConfigWriteData, 0);
    rst_n = 1'b1;
    tick();

    // Test 1: port1 session with three back-to-back words
    bus.PortActive = 3'b010;
    tick();
    chk("t1_fsmreset", 32'(bus.FSMReset), 1);
    chk("t1_activeport", 32'(bus.ActivePort), 1);
    chk("t1_busy", 32'(bus.Busy), 1);
    chk("t1_strobe_idle", 32'(bus.ConfigWriteStrobe), 0);
    bus.PortWriteData[63:32] = 32'hA;
    bus.PortWriteStrobe      = 3'b010;
    tick();
    chk("t1_fsmreset_once", 32'(bus.FSMReset), 0);
    chk("t1_w0_strobe", 32'(bus.ConfigWriteStrobe), 1);
    chk("t1_w0_data", bus.ConfigWriteData, 32'hA);
    bus.PortWriteData[63:32] = 32'hB;
    tick();
    chk("t1_w1_data", bus.ConfigWriteData, 32'hB);
    bus.PortWriteData[63:32] = 32'hC;
    tick();
    chk("t1_w2_data", bus.ConfigWriteData, 32'hC);
    bus.PortWriteStrobe = 3'b000;
    tick();
    chk("t1_strobe_off", 32'(bus.ConfigWriteStrobe), 0);
    chk("t1_data_held", bus.ConfigWriteData, 32'hC);
    chk("t1_wordcount", 32'(bus.WordCount), 3);

    // Test 3: 10-cycle Active gap is bridged by HOLD, then a full 16-cycle drop releases
    bus.PortActive = 3'b000;
    tick(10);
    chk("t3_gap_busy", 32'(bus.Busy), 1);
    chk("t3_gap_activeport", 32'(bus.ActivePort), 1);
    bus.PortActive = 3'b010;
    tick();
    chk("t3_regrant_fsmreset", 32'(bus.FSMReset), 0);
    chk("t3_regrant_wordcount", 32'(bus.WordCount), 3);
    chk("t3_regrant_busy", 32'(bus.Busy), 1);
    bus.PortActive = 3'b000;
    tick(16);
    chk("t3_hold_last_busy", 32'(bus.Busy), 1);
    tick();
    chk("t3_idle_busy", 32'(bus.Busy), 0);
    chk("t3_idle_activeport", 32'(bus.ActivePort), 0);
    chk("t3_idle_wordcount", 32'(bus.WordCount), 3);
    tick();
    chk("t3_idle_data_zero", bus.ConfigWriteData, 0);

    // Test 2: port2 granted (strobe in arbitration cycle dropped), port0 cannot preempt
    bus.PortActive            = 3'b100;
    bus.PortWriteStrobe       = 3'b100;
    bus.PortWriteData[95:64]  = 32'h55;
    tick();
    chk("t2_fsmreset", 32'(bus.FSMReset), 1);
    chk("t2_activeport", 32'(bus.ActivePort), 2);
    chk("t2_arb_strobe_dropped", 32'(bus.ConfigWriteStrobe), 0);
    chk("t2_wordcount_cleared", 32'(bus.WordCount), 0);
    bus.PortWriteStrobe = 3'b000;
    bus.PortActive      = 3'b101;
    tick();
    chk("t2_no_preempt", 32'(bus.ActivePort), 2);
    chk("t2_no_fsmreset", 32'(bus.FSMReset), 0);
    bus.PortActive = 3'b001;
    tick(16);
    chk("t2_hold_activeport", 32'(bus.ActivePort), 2);
    tick();
    chk("t2_release_busy", 32'(bus.Busy), 0);
    tick();
    chk("t2_port0_fsmreset", 32'(bus.FSMReset), 1);
    chk("t2_port0_busy", 32'(bus.Busy), 1);
    chk("t2_port0_activeport", 32'(bus.ActivePort), 0);
    chk("t2_no_collision", 32'(bus.Collision), 0);

    // Test 4: non-granted port2 strobes while port0 holds the grant
    bus.PortWriteData[31:0]  = 32'h11;
    bus.PortWriteData[95:64] = 32'hDEAD;
    bus.PortWriteStrobe      = 3'b101;
    tick();
    chk("t4_fwd_data", bus.ConfigWriteData, 32'h11);
    chk("t4_collision", 32'(bus.Collision), 1);
    chk("t4_wordcount", 32'(bus.WordCount), 1);
    bus.PortWriteStrobe = 3'b100;
    tick();
    chk("t4_dead_not_fwd_strobe", 32'(bus.ConfigWriteStrobe), 0);
    chk("t4_dead_not_fwd_data", bus.ConfigWriteData, 32'h11);
    bus.PortWriteStrobe = 3'b000;
    bus.PortActive      = 3'b000;
    tick(18);
    chk("t4_session_over", 32'(bus.Busy), 0);
    chk("t4_collision_sticky", 32'(bus.Collision), 1);

    // Test 5: reset in the middle of a burst
    bus.PortActive = 3'b010;
    tick();
    chk("t5_grant", 32'(bus.FSMReset), 1);
    bus.PortWriteData[63:32] = 32'h77;
    bus.PortWriteStrobe      = 3'b010;
    tick();
    chk("t5_fwd", bus.ConfigWriteData, 32'h77);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_busy", 32'(bus.Busy), 0);
    chk("t5_rst_strobe", 32'(bus.ConfigWriteStrobe), 0);
    chk("t5_rst_data", bus.ConfigWriteData, 0);
    chk("t5_rst_wordcount", 32'(bus.WordCount), 0);
    chk("t5_rst_collision", 32'(bus.Collision), 0);
    chk("t5_rst_fsmreset", 32'(bus.FSMReset), 0);
    chk("t5_rst_activeport", 32'(bus.ActivePort), 0);
    rst_n               = 1'b1;
    bus.PortWriteStrobe = 3'b000;
    tick();
    chk("t5_rearb_fsmreset", 32'(bus.FSMReset), 1);
    chk("t5_rearb_activeport", 32'(bus.ActivePort), 1);
    chk("t5_rearb_busy", 32'(bus.Busy), 1);

    // Test 6: 2-bit count saturation, checksum wrap, zero-cycle hold on the small instance
    sbus.PortActive = 3'b001;
    tick();
    chk("t6_grant", 32'(sbus.FSMReset), 1);
    sbus.PortWriteData[31:0] = 32'hFFFF_FFFF;
    sbus.PortWriteStrobe     = 3'b001;
    tick();
    chk("t6_wc1", 32'(sbus.WordCount), 1);
    sbus.PortWriteData[31:0] = 32'h2;
    tick();
    chk("t6_wc2", 32'(sbus.WordCount), 2);
    chk("t6_data2", sbus.ConfigWriteData, 32'h2);
`ifdef CONFIG_CHECKSUM_EN
    chk("t6_checksum_wrap", sbus.Checksum, 32'h1);
`endif
    sbus.PortWriteData[31:0] = 32'h0;
    tick();
    chk("t6_wc3", 32'(sbus.WordCount), 3);
    tick(2);
    chk("t6_wc_saturated", 32'(sbus.WordCount), 3);
`ifdef CONFIG_CHECKSUM_EN
    chk("t6_checksum_after5", sbus.Checksum, 32'h1);
`endif
    sbus.PortWriteStrobe = 3'b000;
    sbus.PortActive      = 3'b000;
    tick();
    chk("t6_hold0_release", 32'(sbus.Busy), 0);
    sbus.PortActive = 3'b001;
    tick();
    chk("t6_regrant_fsmreset", 32'(sbus.FSMReset), 1);
    chk("t6_regrant_wc", 32'(sbus.WordCount), 0);
`ifdef CONFIG_CHECKSUM_EN
    chk("t6_regrant_checksum", sbus.Checksum, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
